// File: rtl/interlace_timing_decoder_pkg.sv
// Shared types and default timing for the interlaced-input timing decoder.
package interlace_pkg;

    typedef enum logic [1:0] {
        UNLOCKED = 2'd0,
        CHECK    = 2'd1,
        LOCKED   = 2'd2
    } lock_state_e;

    typedef enum logic [1:0] {
        P0   = 2'd0,
        P1   = 2'd1,
        PINV = 2'd2
    } parity_e;

    localparam int H_TOTAL_DEF     = 944;
    localparam int HALF_LINE_DEF   = 472;
    localparam int PARITY_TOL_DEF  = 16;
    localparam int LOCK_FIELDS_DEF = 4;

    function automatic logic parity_bit(input parity_e p);
        return (p == P1);
    endfunction

endpackage

// File: rtl/interlace_timing_decoder_if.sv
// Video stream bundle between the input port and the timing decoder.
interface interlace_timing_decoder_if #(
    parameter int DW = 16,
    parameter int CW = 12
);
    logic          vsync_i;
    logic          hsync_i;
    logic          de_i;
    logic [DW-1:0] data_i;
    logic          vs_o;
    logic          hs_o;
    logic          de_o;
    logic [DW-1:0] data_o;
    logic          field_o;
    logic [CW-1:0] x_o;
    logic [CW-1:0] y_o;
    logic          sof_o;
    logic [CW-1:0] field_lines_o;
    logic          locked_o;
    logic          err_o;

    modport slave (
        input  vsync_i, hsync_i, de_i, data_i,
        output vs_o, hs_o, de_o, data_o, field_o, x_o, y_o, sof_o,
               field_lines_o, locked_o, err_o
    );

    modport master (
        output vsync_i, hsync_i, de_i, data_i,
        input  vs_o, hs_o, de_o, data_o, field_o, x_o, y_o, sof_o,
               field_lines_o, locked_o, err_o
    );
endinterface

// File: rtl/interlace_timing_decoder_field_parity_detect.sv
// Tracks clocks since the last hsync rise, flags a missing-hsync timeout and
// classifies the vsync-to-hsync offset into a field parity.
module field_parity_detect
    import interlace_pkg::*;
#(
    parameter int H_TOTAL    = H_TOTAL_DEF,
    parameter int HALF_LINE  = HALF_LINE_DEF,
    parameter int PARITY_TOL = PARITY_TOL_DEF,
    parameter int CW         = 12
) (
    input  logic    clk,
    input  logic    rstn,
    input  logic    hs_rise_i,
    input  logic    vs_rise_i,
    output logic    par_stb_o,
    output parity_e par_o,
    output logic    timeout_o
);
    localparam logic [CW-1:0] H_MAX = CW'(2 * H_TOTAL);
    localparam logic [CW-1:0] P0_LO = CW'(PARITY_TOL);
    localparam logic [CW-1:0] P0_HI = CW'(H_TOTAL - PARITY_TOL);
    localparam logic [CW-1:0] P1_LO = CW'(HALF_LINE - PARITY_TOL);
    localparam logic [CW-1:0] P1_HI = CW'(HALF_LINE + PARITY_TOL);

    logic [CW-1:0] h_pos_q;
    logic [CW-1:0] h_pos_d;

    // h_pos_d is this cycle's position; a coincident hsync rise makes it 0
    always_comb begin
        h_pos_d   = h_pos_q;
        timeout_o = 1'b0;
        if (hs_rise_i) begin
            h_pos_d = '0;
        end else if (h_pos_q != H_MAX) begin
            h_pos_d   = h_pos_q + 1'b1;
            timeout_o = (h_pos_d == H_MAX);
        end else begin
            h_pos_d = h_pos_q;
        end
    end

    // Offset classifier, meaningful only on the vsync-rise strobe
    always_comb begin
        par_stb_o = vs_rise_i;
        par_o     = PINV;
        if ((h_pos_d <= P0_LO) || (h_pos_d >= P0_HI)) begin
            par_o = P0;
        end else if ((h_pos_d >= P1_LO) && (h_pos_d <= P1_HI)) begin
            par_o = P1;
        end else begin
            par_o = PINV;
        end
    end

    // Line position register
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            h_pos_q <= '0;
        end else begin
            h_pos_q <= h_pos_d;
        end
    end

endmodule

// File: rtl/interlace_timing_decoder.sv
// Recovers field parity, pixel/line coordinates and timing lock from an
// interlaced sync/DE/pixel stream; all outputs lag the inputs by one clock.
module interlace_timing_decoder
    import interlace_pkg::*;
#(
    parameter int H_TOTAL     = H_TOTAL_DEF,
    parameter int HALF_LINE   = HALF_LINE_DEF,
    parameter int PARITY_TOL  = PARITY_TOL_DEF,
    parameter int LOCK_FIELDS = LOCK_FIELDS_DEF,
    parameter int DW          = 16,
    parameter int CW          = 12
) (
    input  logic                       clk,
    input  logic                       rstn,
    interlace_timing_decoder_if.slave  vid
);
    localparam logic [CW-1:0] LOCK_N = CW'(LOCK_FIELDS);
    localparam logic [CW-1:0] ONE    = CW'(1);

    // The delayed copies double as the edge-detect history
    logic          vs_q, hs_q, de_q;
    logic [DW-1:0] data_q;
    logic          field_q, field_d, sof_q, err_q, err_d, locked_q;
    logic          last_par_q, last_par_d;
    logic [CW-1:0] x_q, x_d, x_o_q, x_o_d, y_o_q, y_o_d;
    logic [CW-1:0] field_line_q, field_line_d, fl_cur_s;
    logic [CW-1:0] hs_cnt_q, hs_cnt_d, hs_inc_s, field_lines_q, field_lines_d;
    logic [CW-1:0] good_q, good_d;
    lock_state_e   state_q, state_d;
    logic          vs_rise_s, hs_rise_s, de_rise_s, de_fall_s;
    logic          par_stb_s, timeout_s, par_valid_s, par_bit_s, lock_drop_s;
    parity_e       par_s;

    assign vs_rise_s   = vid.vsync_i & ~vs_q;
    assign hs_rise_s   = vid.hsync_i & ~hs_q;
    assign de_rise_s   = vid.de_i & ~de_q;
    assign de_fall_s   = ~vid.de_i & de_q;
    assign par_valid_s = (par_s != PINV);
    assign par_bit_s   = parity_bit(par_s);

    field_parity_detect #(
        .H_TOTAL    (H_TOTAL),
        .HALF_LINE  (HALF_LINE),
        .PARITY_TOL (PARITY_TOL),
        .CW         (CW)
    ) u_parity (
        .clk       (clk),
        .rstn      (rstn),
        .hs_rise_i (hs_rise_s),
        .vs_rise_i (vs_rise_s),
        .par_stb_o (par_stb_s),
        .par_o     (par_s),
        .timeout_o (timeout_s)
    );

    // Line/pixel counters and field parity; hsync is counted before vsync latches
    always_comb begin
        x_d           = x_q;
        x_o_d         = '0;
        y_o_d         = '0;
        field_d       = field_q;
        field_lines_d = field_lines_q;
        field_line_d  = field_line_q;
        fl_cur_s      = field_line_q;
        hs_inc_s      = (hs_rise_s && (hs_cnt_q != '1)) ? hs_cnt_q + 1'b1 : hs_cnt_q;
        hs_cnt_d      = hs_inc_s;
        if (vs_rise_s) begin
            field_lines_d = hs_inc_s;
            hs_cnt_d      = '0;
            field_line_d  = '0;
            fl_cur_s      = '0;
        end else if (de_fall_s) begin
            field_line_d = field_line_q + 1'b1;
        end else begin
            field_line_d = field_line_q;
        end
        if (par_stb_s) begin
            case (par_s)
                P0:      field_d = 1'b0;
                P1:      field_d = 1'b1;
                default: field_d = ~field_q;
            endcase
        end else begin
            field_d = field_q;
        end
        if (vid.de_i) begin
            x_d   = de_rise_s ? '0 : x_q + 1'b1;
            x_o_d = x_d;
            y_o_d = CW'({fl_cur_s, field_d});
        end else begin
            x_d = x_q;
        end
    end

    // Lock tracking, advanced at each vsync rise; a timeout always unlocks
    always_comb begin
        state_d     = state_q;
        good_d      = good_q;
        lock_drop_s = 1'b0;
        last_par_d  = (par_stb_s && par_valid_s) ? par_bit_s : last_par_q;
        if (timeout_s) begin
            state_d = UNLOCKED;
            good_d  = '0;
        end else if (par_stb_s) begin
            case (state_q)
                UNLOCKED: begin
                    if (par_valid_s) begin
                        state_d = CHECK;
                        good_d  = ONE;
                    end else begin
                        state_d = UNLOCKED;
                        good_d  = '0;
                    end
                end
                CHECK: begin
                    if (par_valid_s && (par_bit_s != last_par_q)) begin
                        good_d  = good_q + 1'b1;
                        state_d = (good_d == LOCK_N) ? LOCKED : CHECK;
                    end else if (par_valid_s) begin
                        good_d  = ONE;
                        state_d = CHECK;
                    end else begin
                        good_d  = '0;
                        state_d = UNLOCKED;
                    end
                end
                LOCKED: begin
                    if (!par_valid_s || (par_bit_s == last_par_q)) begin
                        state_d     = UNLOCKED;
                        good_d      = '0;
                        lock_drop_s = 1'b1;
                    end else begin
                        state_d = LOCKED;
                    end
                end
                default: begin
                    state_d = UNLOCKED;
                    good_d  = '0;
                end
            endcase
        end else begin
            state_d = state_q;
        end
        err_d = timeout_s | (par_stb_s & ~par_valid_s) | lock_drop_s;
    end

    // Output pipeline and state registers
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            vs_q          <= 1'b0;
            hs_q          <= 1'b0;
            de_q          <= 1'b0;
            data_q        <= '0;
            field_q       <= 1'b0;
            sof_q         <= 1'b0;
            err_q         <= 1'b0;
            locked_q      <= 1'b0;
            last_par_q    <= 1'b0;
            x_q           <= '0;
            x_o_q         <= '0;
            y_o_q         <= '0;
            field_line_q  <= '0;
            hs_cnt_q      <= '0;
            field_lines_q <= '0;
            good_q        <= '0;
            state_q       <= UNLOCKED;
        end else begin
            vs_q          <= vid.vsync_i;
            hs_q          <= vid.hsync_i;
            de_q          <= vid.de_i;
            data_q        <= vid.data_i;
            field_q       <= field_d;
            sof_q         <= vs_rise_s;
            err_q         <= err_d;
            locked_q      <= (state_d == LOCKED);
            last_par_q    <= last_par_d;
            x_q           <= x_d;
            x_o_q         <= x_o_d;
            y_o_q         <= y_o_d;
            field_line_q  <= field_line_d;
            hs_cnt_q      <= hs_cnt_d;
            field_lines_q <= field_lines_d;
            good_q        <= good_d;
            state_q       <= state_d;
        end
    end

    assign vid.vs_o          = vs_q;
    assign vid.hs_o          = hs_q;
    assign vid.de_o          = de_q;
    assign vid.data_o        = data_q;
    assign vid.field_o       = field_q;
    assign vid.x_o           = x_o_q;
    assign vid.y_o           = y_o_q;
    assign vid.sof_o         = sof_q;
    assign vid.field_lines_o = field_lines_q;
    assign vid.locked_o      = locked_q;
    assign vid.err_o         = err_q;

endmodule

// File: tb/tb_interlace_timing_decoder.sv
// Directed bench: scaled-down interlaced frames (100-clk lines, 13-line frames)
// exercising parity decode, coordinates, lock, errors, timeout and mid-line reset.
module tb_interlace_timing_decoder;
    localparam int H_T = 100;
    localparam int ACT = 20;

    logic clk;
    logic rstn;
    interlace_timing_decoder_if #(.DW(16), .CW(12)) vif ();

    interlace_timing_decoder #(
        .H_TOTAL(H_T), .HALF_LINE(50), .PARITY_TOL(4), .LOCK_FIELDS(4), .DW(16), .CW(12)
    ) dut (
        .clk  (clk),
        .rstn (rstn),
        .vid  (vif)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int   n_pass = 0;
    int   n_tot  = 0;
    int   n_sof, n_err, err_at, lock_on_at, lock_off_at, cur_line;
    int   fl_a, fl_b;
    logic f_a, f_b;
    logic lock_prev = 1'b0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tot++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    endtask

    task automatic step(input logic v, input logic hs, input logic de, input logic [15:0] d);
        vif.vsync_i = v;
        vif.hsync_i = hs;
        vif.de_i    = de;
        vif.data_i  = d;
        @(negedge clk);
    endtask

    task automatic tally(input int pos);
        if (vif.sof_o) n_sof++;
        if (vif.err_o) begin
            n_err++;
            err_at = pos;
        end
        if (vif.locked_o && !lock_prev) lock_on_at = pos;
        if (!vif.locked_o && lock_prev) lock_off_at = pos;
        lock_prev = vif.locked_o;
    endtask

    // One 100-clk line: hsync 8 clks, vsync from vs_at (if >=0) to line end, 20 active pixels
    task automatic send_line(input int vs_at, input logic act, input int fl, input logic fld);
        logic v, hs, de;
        logic [15:0] d;
        for (int h = 0; h < H_T; h++) begin
            v  = (vs_at >= 0) && (h >= vs_at);
            hs = (h < 8);
            de = act && (h >= 20) && (h < 20 + ACT);
            d  = 16'(cur_line * 256 + h);
            step(v, hs, de, d);
            tally(cur_line * H_T + h);
            chk("de_o", vif.de_o, de);
            chk("data_o", vif.data_o, d);
            if (de) begin
                chk("x_o", vif.x_o, h - 20);
                chk("y_o", vif.y_o, 2 * fl + fld);
            end
        end
        cur_line++;
    endtask

    // Frame: field 0 VS at line 0 h=0, field 1 VS at line 6 h=vs1; 4 active lines per field
    task automatic send_frame(input int vs1, input logic f1);
        n_sof = 0; n_err = 0; err_at = -1; lock_on_at = -1; lock_off_at = -1; cur_line = 0;
        send_line(0, 1'b0, 0, 1'b0);
        f_a  = vif.field_o;
        fl_a = int'(vif.field_lines_o);
        for (int i = 0; i < 4; i++) send_line(-1, 1'b1, i, 1'b0);
        send_line(-1, 1'b0, 0, 1'b0);
        send_line(vs1, 1'b0, 0, 1'b0);
        f_b  = vif.field_o;
        fl_b = int'(vif.field_lines_o);
        send_line(-1, 1'b0, 0, 1'b0);
        for (int i = 0; i < 4; i++) send_line(-1, 1'b1, i, f1);
        send_line(-1, 1'b0, 0, 1'b0);
    endtask

    initial begin
        rstn = 1'b0;
        vif.vsync_i = 1'b0; vif.hsync_i = 1'b0; vif.de_i = 1'b0; vif.data_i = 16'hABCD;
        repeat (3) @(negedge clk);
        chk("rst_vs", vif.vs_o, 0);
        chk("rst_hs", vif.hs_o, 0);
        chk("rst_de", vif.de_o, 0);
        chk("rst_data", vif.data_o, 0);
        chk("rst_field", vif.field_o, 0);
        chk("rst_x", vif.x_o, 0);
        chk("rst_y", vif.y_o, 0);
        chk("rst_sof", vif.sof_o, 0);
        chk("rst_flines", vif.field_lines_o, 0);
        chk("rst_locked", vif.locked_o, 0);
        chk("rst_err", vif.err_o, 0);
        rstn = 1'b1;
        repeat (3) step(1'b0, 1'b0, 1'b0, 16'h0000);

        // Frame 1: parity alternates, first latch counts only the coincident hsync
        send_frame(50, 1'b1);
        chk("f1_field_a", f_a, 0);
        chk("f1_field_b", f_b, 1);
        chk("f1_flines_a", fl_a, 1);
        chk("f1_flines_b", fl_b, 6);
        chk("f1_sof", n_sof, 2);
        chk("f1_err", n_err, 0);
        chk("f1_locked", vif.locked_o, 0);

        // Frame 2: fourth alternating vsync rise locks
        send_frame(50, 1'b1);
        chk("f2_flines_a", fl_a, 7);
        chk("f2_flines_b", fl_b, 6);
        chk("f2_lock_on", lock_on_at, 650);
        chk("f2_sof", n_sof, 2);
        chk("f2_err", n_err, 0);

        // Frame 3: field-1 VS at h=20 is invalid; parity is predicted
        send_frame(20, 1'b1);
        chk("f3_err", n_err, 1);
        chk("f3_err_at", err_at, 620);
        chk("f3_lock_off", lock_off_at, 620);
        chk("f3_field_b", f_b, 1);
        chk("f3_locked", vif.locked_o, 0);

        // Frames 4-5: relock after four good fields
        send_frame(50, 1'b1);
        chk("f4_locked", vif.locked_o, 0);
        chk("f4_err", n_err, 0);
        send_frame(50, 1'b1);
        chk("f5_lock_on", lock_on_at, 650);

        // Frame 6: repeated parity 0 while locked
        send_frame(0, 1'b0);
        chk("f6_err", n_err, 1);
        chk("f6_err_at", err_at, 600);
        chk("f6_lock_off", lock_off_at, 600);
        chk("f6_field_b", f_b, 0);
        chk("f6_flines_b", fl_b, 6);

        // Frames 7-8: check restarts without error, relocks
        send_frame(50, 1'b1);
        chk("f7_err", n_err, 0);
        chk("f7_locked", vif.locked_o, 0);
        send_frame(50, 1'b1);
        chk("f8_lock_on", lock_on_at, 650);

        // Missing hsync: last rise at line 12 h=0, so h_pos hits 200 on idle clk 101
        n_err = 0; err_at = -1; lock_off_at = -1;
        for (int k = 1; k <= 250; k++) begin
            step(1'b0, 1'b0, 1'b0, 16'h0000);
            tally(k);
        end
        chk("to_err_count", n_err, 1);
        chk("to_err_at", err_at, 101);
        chk("to_lock_off", lock_off_at, 101);
        chk("to_locked", vif.locked_o, 0);

        // Frame 9: recovery on the next hsync
        send_frame(50, 1'b1);
        chk("f9_err", n_err, 0);
        chk("f9_field_a", f_a, 0);
        chk("f9_field_b", f_b, 1);
        chk("f9_flines_a", fl_a, 7);

        // Reset asserted mid-line at pixel x=10
        cur_line = 0;
        for (int h = 0; h <= 30; h++) step(1'b0, (h < 8), (h >= 20), 16'(h));
        chk("pre_rst_x", vif.x_o, 10);
        rstn = 1'b0;
        #1;
        chk("mid_rst_de", vif.de_o, 0);
        chk("mid_rst_data", vif.data_o, 0);
        chk("mid_rst_x", vif.x_o, 0);
        chk("mid_rst_field", vif.field_o, 0);
        chk("mid_rst_flines", vif.field_lines_o, 0);
        repeat (2) step(1'b0, 1'b0, 1'b0, 16'h0000);
        rstn = 1'b1;
        n_sof = 0;
        send_line(-1, 1'b1, 0, 1'b0);
        chk("post_rst_sof", n_sof, 0);
        send_frame(50, 1'b1);
        chk("post_rst_frame_sof", n_sof, 2);
        chk("post_rst_field_a", f_a, 0);
        chk("post_rst_field_b", f_b, 1);

        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end

endmodule

// File: doc/interlace_timing_decoder.md
Name: interlace_timing_decoder

Overview:
- Receive-side counterpart of the interlacer: consumes an interlaced sync/DE/pixel stream (two fields per frame, second field's VS offset by half a line) and recovers field parity, pixel x, frame-line y and timing lock.
- Sits at the HDMI/parallel video input, ahead of any deinterlacer or frame writer.
- Outputs are a 1-cycle-registered, aligned copy of the input stream plus decoded coordinates.

Parameters:
- H_TOTAL, 944, clocks per line
- HALF_LINE, 472, VS-to-HS offset identifying field 1
- PARITY_TOL, 16, ± clock window for offset classification
- LOCK_FIELDS, 4, consecutive good fields to assert lock
- DW, 16, pixel data width
- CW, 12, counter width

Ports:
- clk  in  1  pixel clock
- rstn  in  1  asynchronous active-low reset
- vsync_i  in  1  vertical sync, active high
- hsync_i  in  1  horizontal sync, active high
- de_i  in  1  data enable
- data_i  in  DW  pixel data
- vs_o  out  1  vsync_i delayed 1 clk
- hs_o  out  1  hsync_i delayed 1 clk
- de_o  out  1  de_i delayed 1 clk
- data_o  out  DW  data_i delayed 1 clk
- field_o  out  1  decoded field parity (0 = top/even, 1 = bottom/odd)
- x_o  out  CW  pixel index within active line, valid while de_o
- y_o  out  CW  frame line = 2*field_line + field_o, valid while de_o
- sof_o  out  1  1-clk pulse at start of each field
- field_lines_o  out  CW  hsync count of the last completed field
- locked_o  out  1  timing lock
- err_o  out  1  1-clk pulse on a timing violation

Behaviour:
- Reset: all outputs 0; FSM UNLOCKED; counters 0.
- Edge detect: registered previous vsync/hsync/de; rising edges are single-cycle strobes.
- h_pos: 0 on hsync rise, else +1, saturating at 2*H_TOTAL.
  - Reaching 2*H_TOTAL is a missing-hsync timeout: err_o pulses once, FSM goes to UNLOCKED.
- Field classification at vsync rise, using h_pos sampled that cycle:
  - h_pos ≤ PARITY_TOL or h_pos ≥ H_TOTAL−PARITY_TOL → parity 0.
  - |h_pos−HALF_LINE| ≤ PARITY_TOL → parity 1.
  - Otherwise invalid: err_o pulses; field_o toggles from its previous value (predicted).
- field_o updates the cycle after the vsync rise; sof_o pulses the same cycle.
- Vertical sync and edge priority:
  - If vsync rise and hsync rise coincide, hsync rise is processed first; h_pos is treated as 0, giving parity 0.
  - At vsync rise, the field's hsync count is latched to field_lines_o (e.g. 312/313), then cleared.
  - The hsync counter saturates at all-ones.
- Active counters:
  - x: 0 on de rise, +1 per de-high clock; x_o = x for that pixel.
  - field_line: 0 at vsync rise, +1 on each de fall.
  - y_o = {field_line[CW-2:0], field_o}; the MSB of field_line is discarded on wrap.
- Latency: every *_o is exactly 1 clk after the corresponding input. x_o/y_o are coherent with de_o/data_o.
- Lock FSM, evaluated at each vsync rise:
  - UNLOCKED: valid parity → CHECK with good=1.
  - CHECK: parity valid and opposite to previous → good+1; at good==LOCK_FIELDS → LOCKED. Invalid or repeated parity → good=1 if valid, else UNLOCKED.
  - LOCKED: locked_o=1. Any invalid parity, repeated parity, or timeout → UNLOCKED (locked_o drops the next clk, err_o pulses).
- Reset mid-field: immediate clear. The first partial field after release produces no sof_o until the next vsync rise.

Decomposition:
- Package interlace_pkg: lock-state enum (UNLOCKED, CHECK, LOCKED), parity-result enum (P0, P1, PINV), default H_TOTAL/HALF_LINE constants.
- One sub-module, field_parity_detect: owns the h_pos counter, timeout and offset classifier; emits parity result and strobe.

Test Plan:
- Interlaced 944-clk lines; field0 312 lines with VS at h_pos 0, field1 313 lines with VS at h_pos 472, 288 active lines of 768 → field_o alternates 0/1; field_lines_o 312 then 313; first pixel x_o=0, last x_o=767; y_o runs 0,2,…,574 in field0 and 1,3,…,575 in field1.
- Same stream from reset → locked_o rises 1 clk after the 4th consecutive alternating vsync rise; sof_o pulses once per field.
- While locked, one field VS at h_pos 200 → err_o pulses 1 clk; locked_o drops; field_o toggles (predicted); relock after 4 further good fields.
- Two consecutive parity-0 fields while locked → err_o pulse, UNLOCKED, CHECK restarted.
- hsync held low 1888 clks → single err_o pulse at h_pos=1888; locked_o=0; h_pos saturated; recovers on the next hsync.
- rstn asserted mid-line at x=300 → all outputs 0 in the same cycle; after release, no sof_o until the next vsync rise; data_o/de_o resume with 1-clk latency.
